seg7_bcd_counter_mux: RTL and testbench

Parametrised successor to the single-digit 7-segment decimal counter. Holds a DIGITS-wide BCD up/down counter that advances on a prescaled tick. Drives a time-multiplexed common-anode display: one shared active-low segment bus plus an active-low per-digit enable. Sits between the board clock and the display pins; no bus interface.

---
 rtl/seg7_bcd_counter_mux_pkg.sv | 40 ++++
 rtl/seg7_bcd_counter_mux_bcd_digit.sv | 35 +++
 rtl/seg7_bcd_counter_mux.sv | 123 ++++++++++++
 tb/tb_seg7_bcd_counter_mux.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg7_bcd_counter_mux_pkg.sv
// Shared constants and helpers for the multiplexed BCD display counter:
// active-low {a..g} segment codes, the BCD-to-segment encoder and the
// scan-index width rule.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h0C;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Non-BCD nibbles blank the digit rather than showing garbage.
   function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
      case (nib)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Scan index width: $clog2(DIGITS), but never below one bit.
   function automatic int seg7_idx_w(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/seg7_bcd_counter_mux_bcd_digit.sv
// One BCD digit of the up/down chain. step_i is the carry/borrow arriving
// from the digit below; carry_o fires when this digit rolls over (9->0 up,
// 0->9 down) so it can step the digit above.
module bcd_digit (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       step_i,
   input  logic       up_i,
   output logic [3:0] digit_o,
   output logic       carry_o
);

   logic [3:0] dig_q, dig_d;

   // Next digit value and roll-over detection; out-of-range values recover to 0/9.
   always_comb begin
      dig_d   = dig_q;
      carry_o = step_i & (up_i ? (dig_q >= 4'd9) : (dig_q == 4'd0));
      if (step_i) begin
         if (up_i) dig_d = (dig_q >= 4'd9) ? 4'd0 : dig_q + 4'd1;
         else      dig_d = (dig_q == 4'd0 || dig_q > 4'd9) ? 4'd9 : dig_q - 4'd1;
      end
   end

   // Digit register: reset, then clear, then step.
   always_ff @(posedge clk_i) begin
      if (!rst_i)      dig_q <= 4'd0;
      else if (clr_i)  dig_q <= 4'd0;
      else             dig_q <= dig_d;
   end

   assign digit_o = dig_q;

endmodule

// File: rtl/seg7_bcd_counter_mux.sv
// DIGITS-wide BCD up/down counter stepped by a TICK_DIV prescaler, driving a
// time-multiplexed common-anode display (shared active-low seg bus, one-cold
// active-low an). Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
// above digit 0.
module seg7_bcd_counter_mux
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 1125000,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  up_dn_i,
   input  logic                  clear_i,
   output logic [6:0]            seg_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  wrap_o,
   output logic [4*DIGITS-1:0]   value_o
);

   localparam int IDX_W = seg7_idx_w(DIGITS);
   localparam int PW    = $clog2(TICK_DIV);
   localparam int SW    = $clog2(SCAN_DIV);

   logic [PW-1:0]              presc_q, presc_d;
   logic                       tick;
   logic [DIGITS:0]            carry;
   logic [DIGITS-1:0][3:0]     dig;
   logic                       wrap_q;
   logic [SW-1:0]              scan_q;
   logic [IDX_W-1:0]           idx_q;
   logic                       scan_tc;
   logic [6:0]                 seg_q, seg_d;
   logic [DIGITS-1:0]          an_q, an_d;

   // Prescaler next state: free-runs while enabled, tick on terminal count.
   always_comb begin
      tick    = en_i && (presc_q == PW'(TICK_DIV - 1));
      presc_d = presc_q;
      if (en_i) presc_d = tick ? '0 : presc_q + 1'b1;
   end

   // Prescaler register; clear restarts the phase.
   always_ff @(posedge clk_i) begin
      if (!rst_i)        presc_q <= '0;
      else if (clear_i)  presc_q <= '0;
      else               presc_q <= presc_d;
   end

   // A tick coinciding with clear is dropped here, so clear also masks wrap.
   assign carry[0] = tick & ~clear_i;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clr_i   (clear_i),
         .step_i  (carry[g]),
         .up_i    (up_dn_i),
         .digit_o (dig[g]),
         .carry_o (carry[g+1])
      );
   end

   // Carry out of the top digit is a full wrap; registered alongside the value.
   always_ff @(posedge clk_i) begin
      if (!rst_i) wrap_q <= 1'b0;
      else        wrap_q <= carry[DIGITS];
   end

   assign scan_tc = (scan_q == SW'(SCAN_DIV - 1));

   // Scan timer and digit index; ignores en and clear.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         scan_q <= '0;
         idx_q  <= '0;
      end else begin
         scan_q <= scan_tc ? '0 : scan_q + 1'b1;
         if (scan_tc) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // lz[i]: digit i and all digits above it are zero.
   logic [DIGITS-1:0] lz;
   for (genvar g = 0; g < DIGITS; g++) begin : g_lz
      if (g == DIGITS - 1) begin : g_top
         assign lz[g] = (dig[g] == 4'd0);
      end else begin : g_mid
         assign lz[g] = lz[g+1] & (dig[g] == 4'd0);
      end
   end
`endif

   // Segment/anode drive for the currently scanned slot.
   always_comb begin
      seg_d = seg7_encode(dig[idx_q]);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_q != '0 && lz[idx_q]) seg_d = SEG_BLANK;
`endif
      an_d  = ~(DIGITS'(1) << idx_q);
   end

   // Display outputs are registered so the pins never glitch mid-cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg_o   = seg_q;
   assign an_o    = an_q;
   assign wrap_o  = wrap_q;
   assign value_o = dig;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Scoreboard bench for seg7_bcd_counter_mux (DIGITS=2, TICK_DIV=4, SCAN_DIV=3).
// The reference model keeps the count as a plain integer and derives digits
// with division; expected outputs are queued per cycle and checked by a monitor.
module tb_seg7_bcd_counter_mux;

   localparam int D = 2;
   localparam int T = 4;
   localparam int S = 3;

   logic           clk = 1'b0;
   logic           rst_i, en_i, up_dn_i, clear_i;
   logic [6:0]     seg_o;
   logic [D-1:0]   an_o;
   logic           wrap_o;
   logic [4*D-1:0] value_o;

   always #5 clk = ~clk;

   seg7_bcd_counter_mux #(.DIGITS(D), .TICK_DIV(T), .SCAN_DIV(S)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .up_dn_i (up_dn_i),
      .clear_i (clear_i),
      .seg_o   (seg_o),
      .an_o    (an_o),
      .wrap_o  (wrap_o),
      .value_o (value_o)
   );

   typedef struct {
      logic [6:0]     seg;
      logic [D-1:0]   an;
      logic           wrap;
      logic [4*D-1:0] value;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state
   int          m_val = 0, m_pre = 0, m_scnt = 0, m_idx = 0;
   logic [6:0]  m_seg = 7'h7F;
   logic [D-1:0] m_an = '1;
   logic        m_wrap = 1'b0;

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] enc(input int d);
      logic [6:0] tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                               7'h24, 7'h20, 7'h0F, 7'h00, 7'h0C};
      return tbl[d];
   endfunction

   function automatic logic [4*D-1:0] to_bcd(input int v);
      logic [4*D-1:0] r = '0;
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, queue the expected outputs.
   task automatic step(input bit r, input bit e, input bit u, input bit c);
      exp_t x;
      bit   tk;
      @(negedge clk);
      rst_i = r; en_i = e; up_dn_i = u; clear_i = c;
      if (!r) begin
         m_val = 0; m_pre = 0; m_scnt = 0; m_idx = 0;
         m_seg = 7'h7F; m_an = '1; m_wrap = 1'b0;
      end else begin
         // display reflects the value and slot before this edge
         m_an  = ~(D'(1) << m_idx);
         m_seg = enc((m_val / pow10(m_idx)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
         if (m_idx > 0 && (m_val / pow10(m_idx)) == 0) m_seg = 7'h7F;
`endif
         if (m_scnt == S - 1) begin
            m_scnt = 0;
            m_idx  = (m_idx + 1) % D;
         end else m_scnt++;
         m_wrap = 1'b0;
         if (c) begin
            m_val = 0; m_pre = 0;
         end else if (e) begin
            tk    = (m_pre == T - 1);
            m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
               if (u) begin
                  m_val++;
                  if (m_val == pow10(D)) begin m_val = 0; m_wrap = 1'b1; end
               end else begin
                  m_val--;
                  if (m_val < 0) begin m_val = pow10(D) - 1; m_wrap = 1'b1; end
               end
            end
         end
      end
      x.seg = m_seg; x.an = m_an; x.wrap = m_wrap; x.value = to_bcd(m_val);
      q.push_back(x);
   endtask

   // Count up until the model reaches target (and, if asked, sits on a tick cycle).
   task automatic steer(input int target, input bit on_tick);
      int n = 0;
      while (!(m_val == target && (!on_tick || m_pre == T - 1)) && n < 1000) begin
         step(1, 1, 1, 0);
         n++;
      end
      tests++;
      if (n >= 1000) begin
         fails++;
         $display("FAIL steer: got model value %0d expected %0d", m_val, target);
      end
   endtask

   // Monitor: outputs are valid every cycle, compare one expectation per edge.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         chk("value", 32'(value_o), 32'(x.value));
         chk("wrap",  32'(wrap_o),  32'(x.wrap));
         chk("seg",   32'(seg_o),   32'(x.seg));
         chk("an",    32'(an_o),    32'(x.an));
      end
   end

   initial begin
      rst_i = 1'b0; en_i = 1'b0; up_dn_i = 1'b1; clear_i = 1'b0;
      // reset held for three cycles, then a long up-count through 99->00
      repeat (3) step(0, 0, 1, 0);
      repeat (400) step(1, 1, 1, 0);
      // down through 00->99 and then 98
      steer(0, 1);
      repeat (8) step(1, 1, 0, 0);
      // clear on the exact tick at 37, then watch the prescaler restart
      steer(37, 1);
      step(1, 1, 1, 1);
      repeat (12) step(1, 1, 1, 0);
      // freeze at 05 with scan still running, then resume
      steer(5, 0);
      repeat (20) step(1, 0, 1, 0);
      repeat (8) step(1, 1, 1, 0);
      // randomized traffic
      repeat (3000) step(($urandom % 64) != 0, ($urandom % 4) != 0,
                         $urandom % 2, ($urandom % 40) == 0);
      // reset mid-count at 63
      steer(63, 0);
      step(0, 1, 1, 0);
      repeat (4) step(1, 1, 1, 0);
      // let the monitor drain, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      chk("drain", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
